// File: rtl/uart_rx.sv
// uart_rx: UART receiver. Recovers parallel words from an asynchronous serial
// line (idle high, start low, data LSB first, optional parity, STOP_BITS high
// stop bits) by sampling each bit at mid-period.
//
// Ports:
//   clk          system clock, posedge
//   reset        asynchronous active-high reset
//   rx_in        serial line (asynchronous, idle high)
//   rx_ack       consumer accepts the presented word
//   rx_data      received word, LSB = first data bit on the line
//   rx_valid     rx_data / parity_err / frame_err valid, held until acked
//   parity_err   presented word failed the parity check (0 when PARITY="none")
//   frame_err    a stop bit of the presented word sampled low
//   overrun_err  one-cycle pulse: a completed word was dropped (previous unacked)
//   rx_busy      receiver not in IDLE
module uart_rx #(
    parameter int    WORD_LENGTH = 8,
    parameter string PARITY      = "none",
    parameter int    STOP_BITS   = 1,
    parameter int    BAUD_RATE   = 9600,
    parameter int    CLK_FREQ    = 50_000_000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_in,
    input  logic                   rx_ack,
    output logic [WORD_LENGTH-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   parity_err,
    output logic                   frame_err,
    output logic                   overrun_err,
    output logic                   rx_busy
);

    localparam logic [31:0] CLKS_PER_BIT = 32'(CLK_FREQ / BAUD_RATE);
    localparam logic [31:0] HALF         = CLKS_PER_BIT / 32'd2;
    localparam logic [3:0]  LAST_DATA    = 4'(WORD_LENGTH - 1);
    localparam logic [3:0]  LAST_STOP    = 4'(STOP_BITS - 1);
    localparam bit          PAR_EN       = (PARITY != "none");
    localparam bit          PAR_ODD      = (PARITY == "odd");

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        BRK_WAIT
    } state_t;

    state_t state, state_nx;

    logic                   rx_meta, rx_s;
    logic [31:0]            cnt;
    logic [3:0]             bit_cnt;
    logic [WORD_LENGTH-1:0] shreg;
    logic                   perr, ferr;
    logic                   deliver_q;
    logic                   tick;
    logic                   exp_par;

    // Two-flop synchronizer; both stages reset to the idle (high) level so a
    // reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
        end
    end

    // START waits half a bit to land on the middle of the start bit; every
    // later state then waits a full bit, staying on mid-bit.
    always_comb begin
        tick = 1'b0;
        case (state)
            START:           tick = (cnt == HALF - 32'd1);
            DATA, PAR, STOP: tick = (cnt == CLKS_PER_BIT - 32'd1);
            default:         tick = 1'b0;
        endcase
    end

    assign exp_par = (^shreg) ^ PAR_ODD;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (!rx_s) state_nx = START;
            START:    if (tick) state_nx = rx_s ? IDLE : DATA;
            DATA:     if (tick && bit_cnt == LAST_DATA) state_nx = PAR_EN ? PAR : STOP;
            PAR:      if (tick) state_nx = STOP;
            // Re-arm at mid-stop so a back-to-back start bit is not missed;
            // a low final stop means a break, which must end before re-arming.
            STOP:     if (tick && bit_cnt == LAST_STOP) state_nx = rx_s ? IDLE : BRK_WAIT;
            BRK_WAIT: if (rx_s) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    assign rx_busy = (state != IDLE);

    // Frame datapath: baud counter, bit counter, shift register, error capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            perr      <= 1'b0;
            ferr      <= 1'b0;
            deliver_q <= 1'b0;
        end else begin
            if (state == IDLE || state_nx != state || tick) cnt <= '0;
            else                                           cnt <= cnt + 32'd1;

            if (state_nx != state)
                bit_cnt <= '0;
            else if (tick && (state == DATA || state == STOP))
                bit_cnt <= bit_cnt + 4'd1;

            if (state == DATA && tick)
                shreg <= {rx_s, shreg[WORD_LENGTH-1:1]};

            if (state == START && state_nx == DATA) begin
                perr <= 1'b0;
                ferr <= 1'b0;
            end else begin
                if (state == PAR && tick)
                    perr <= (rx_s != exp_par);
                if (state == STOP && tick && !rx_s)
                    ferr <= 1'b1;
            end

            // Delivery happens the cycle after the last stop sample, so the
            // final stop sample has already been folded into ferr.
            deliver_q <= (state == STOP) && tick && (bit_cnt == LAST_STOP);
        end
    end

    // Output holding register and valid/ack handshake. A delivery coinciding
    // with an ack replaces the word instead of being counted as an overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= deliver_q && rx_valid && !rx_ack;
            if (deliver_q && (!rx_valid || rx_ack)) begin
                rx_data    <= shreg;
                parity_err <= PAR_EN && perr;
                frame_err  <= ferr;
                rx_valid   <= 1'b1;
            end else if (rx_valid && rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
